lcd_digit_streamer: RTL
=======================

Name: lcd_digit_streamer

Overview:
Snapshots a parametrised multi-digit packed BCD value and streams it to the LCD write controller one ASCII character per handshake. Separator characters are inserted at configurable digit positions. Non-decimal codes are mapped to a blank character. It sits between the time/alarm counters and the LCD character writer, and serialises a whole display field per START.

Parameters:
- NUM_DIGITS, 6, number of BCD digits per field (2..16).
- SEP_MASK, 6'b001010, NUM_DIGITS bits; bit i=1 emits SEP_CHAR after digit i (0 = first emitted, most significant); bit NUM_DIGITS-1 ignored.
- SEP_CHAR, 8'h3A, separator ASCII (':').
- BLANK_CHAR, 8'h20, ASCII emitted for invalid BCD (and blanked zeros, see option).

Ports:
- CLK, input, 1, system clock, rising edge.
- RESETN, input, 1, asynchronous active-low reset.
- START, input, 1, request to stream current BCD_IN; sampled only in IDLE.
- BCD_IN, input, 4*NUM_DIGITS, packed BCD; digit 0 = BCD_IN[4*NUM_DIGITS-1 -: 4].
- BUSY, output, 1, high from accepted START until stream done.
- CHAR_VALID, output, 1, CHAR_DATA valid.
- CHAR_DATA, output, 8, ASCII character.
- CHAR_LAST, output, 1, high with final character of field.
- CHAR_READY, input, 1, downstream accepts character.
- DONE, output, 1, one-cycle pulse after last transfer.
- BCD_ERR, output, 1, sticky: any digit >9 seen in current/last field.

Behaviour:
- Reset (async, RESETN=0): state IDLE; BUSY, CHAR_VALID, CHAR_LAST, DONE, BCD_ERR = 0; CHAR_DATA = 8'h00; snapshot and counters cleared. Reset mid-stream aborts with no DONE.
- States: IDLE, DIGIT, SEP, FIN.
- IDLE: START=1 -> latch BCD_IN into snapshot, clear BCD_ERR, digit index=0, go to DIGIT. BUSY and CHAR_VALID rise the next cycle (latency 1).
- DIGIT: CHAR_DATA = 8'h30+digit for 0..9, else BLANK_CHAR and BCD_ERR set. On transfer (CHAR_VALID & CHAR_READY):
  - last digit -> FIN;
  - else SEP_MASK[idx]=1 -> SEP;
  - else idx+1, stay in DIGIT.
- SEP: CHAR_DATA = SEP_CHAR. On transfer, idx+1 -> DIGIT.
- FIN: CHAR_VALID=0, BUSY=0, DONE=1 for one cycle -> IDLE. START during FIN is ignored.
- Handshake: CHAR_VALID never drops and CHAR_DATA/CHAR_LAST never change until transfer. Back-to-back transfers are allowed (one char/cycle when CHAR_READY held high).
- CHAR_LAST = 1 only while emitting the last digit.
- Character count per field = NUM_DIGITS + popcount(SEP_MASK[NUM_DIGITS-2:0]).
- START while BUSY is ignored. BCD_IN changes after acceptance have no effect.
- Index counter width = clog2(NUM_DIGITS). No wrap: FIN is reached on the last digit.

Optional Feature:
- LCD_LEADING_ZERO_BLANK_EN defined: zero digits before the first nonzero digit are emitted as BLANK_CHAR, excluding the final digit, which always prints. Separators preceding the first nonzero digit are also emitted as BLANK_CHAR. Character count is unchanged.
- LCD_LEADING_ZERO_BLANK_EN undefined: all digits are emitted literally.

Decomposition:
- Package lcd_stream_pkg: ASCII_ZERO 8'h30, ASCII_SPACE 8'h20, ASCII_COLON 8'h3A, state enum (IDLE/DIGIT/SEP/FIN), helper function for count width.
- One sub-module bcd_ascii_char: combinational 4-bit BCD -> 8-bit ASCII plus invalid flag, parametrised blank char. Instantiated once on the selected snapshot digit.

Test Plan:
- Defaults, BCD_IN=24'h123456, START pulse, CHAR_READY=1 -> chars "1","2",":","3","4",":","5","6" on 8 consecutive cycles starting cycle after START. CHAR_LAST with "6". DONE one cycle later. BCD_ERR=0.
- BCD_IN=24'h12A456, CHAR_READY toggled 1/0 -> third digit emitted as 8'h20; BCD_ERR=1 after it; data held stable across every READY=0 cycle.
- START re-pulsed mid-stream and BCD_IN changed to 24'h999999 -> stream still "12:34:56", no second stream until IDLE.
- RESETN low during 4th character -> all outputs 0 immediately, no DONE; new START afterwards streams cleanly from digit 0.
- LCD_LEADING_ZERO_BLANK_EN, BCD_IN=24'h000005 -> " ", " ", " ", " ", " ", " ", " ", "5" (8 chars).
- NUM_DIGITS=4, SEP_MASK=4'b0000, BCD_IN=16'h0907 -> "0","9","0","7", CHAR_LAST on "7".

Source files
------------

// File: rtl/lcd_stream_pkg.sv
// rtl/lcd_stream_pkg.sv - shared constants, state encoding and sizing helper for the LCD digit streamer
package lcd_stream_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        SEP   = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Digit index width; never below one bit so a 2-digit field still has a counter.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_ascii_char.sv
// rtl/bcd_ascii_char.sv - combinational BCD nibble to ASCII digit with invalid-code flag
module bcd_ascii_char
    import lcd_stream_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = ASCII_SPACE
) (
    input  logic [3:0] bcd,
    output logic [7:0] ascii,
    output logic       invalid
);

    always_comb begin
        invalid = (bcd > 4'd9);
        ascii   = invalid ? BLANK_CHAR : (ASCII_ZERO + {4'h0, bcd});
    end

endmodule

// File: rtl/lcd_digit_streamer.sv
// rtl/lcd_digit_streamer.sv - snapshots packed BCD and streams it as ASCII chars with separators
// Option macro: LCD_LEADING_ZERO_BLANK_EN blanks leading zeros and the separators before them.
module lcd_digit_streamer
    import lcd_stream_pkg::*;
#(
    parameter int                    NUM_DIGITS = 6,
    parameter logic [NUM_DIGITS-1:0] SEP_MASK   = 6'b001010,
    parameter logic [7:0]            SEP_CHAR   = ASCII_COLON,
    parameter logic [7:0]            BLANK_CHAR = ASCII_SPACE
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic                      START,
    input  logic [4*NUM_DIGITS-1:0]   BCD_IN,
    output logic                      BUSY,
    output logic                      CHAR_VALID,
    output logic [7:0]                CHAR_DATA,
    output logic                      CHAR_LAST,
    input  logic                      CHAR_READY,
    output logic                      DONE,
    output logic                      BCD_ERR
);

    localparam int            IW       = cnt_width(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic                    err_q, err_d;
`ifdef LCD_LEADING_ZERO_BLANK_EN
    logic                    seen_q, seen_d;
`endif

    logic [3:0] digit;
    logic       sep_here;
    logic       is_last;
    logic [7:0] dig_ascii;
    logic       dig_invalid;
    logic       blank_digit;
    logic       blank_sep;

    // Digit 0 lives in the most significant nibble of the snapshot.
    always_comb begin
        digit    = 4'h0;
        sep_here = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                digit    = snap_q[4*(NUM_DIGITS-1-i) +: 4];
                sep_here = SEP_MASK[i] && (i != NUM_DIGITS - 1);
            end
        end
    end

    assign is_last = (idx_q == LAST_IDX);

    bcd_ascii_char #(
        .BLANK_CHAR (BLANK_CHAR)
    ) u_char (
        .bcd     (digit),
        .ascii   (dig_ascii),
        .invalid (dig_invalid)
    );

`ifdef LCD_LEADING_ZERO_BLANK_EN
    assign blank_digit = !seen_q && (digit == 4'h0) && !is_last;
    assign blank_sep   = !seen_q;
`else
    assign blank_digit = 1'b0;
    assign blank_sep   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        err_d      = err_q;
`ifdef LCD_LEADING_ZERO_BLANK_EN
        seen_d     = seen_q;
`endif
        BUSY       = 1'b0;
        CHAR_VALID = 1'b0;
        CHAR_DATA  = 8'h00;
        CHAR_LAST  = 1'b0;
        DONE       = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    snap_d  = BCD_IN;
                    err_d   = 1'b0;
                    idx_d   = '0;
`ifdef LCD_LEADING_ZERO_BLANK_EN
                    seen_d  = 1'b0;
`endif
                    state_d = DIGIT;
                end
            end
            DIGIT: begin
                BUSY       = 1'b1;
                CHAR_VALID = 1'b1;
                CHAR_DATA  = blank_digit ? BLANK_CHAR : dig_ascii;
                CHAR_LAST  = is_last;
                if (dig_invalid) begin
                    err_d = 1'b1;
                end
                if (CHAR_READY) begin
`ifdef LCD_LEADING_ZERO_BLANK_EN
                    if (digit != 4'h0) begin
                        seen_d = 1'b1;
                    end
`endif
                    if (is_last) begin
                        state_d = FIN;
                    end else if (sep_here) begin
                        state_d = SEP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            SEP: begin
                BUSY       = 1'b1;
                CHAR_VALID = 1'b1;
                CHAR_DATA  = blank_sep ? BLANK_CHAR : SEP_CHAR;
                if (CHAR_READY) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = DIGIT;
                end
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            err_q   <= 1'b0;
`ifdef LCD_LEADING_ZERO_BLANK_EN
            seen_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            err_q   <= err_d;
`ifdef LCD_LEADING_ZERO_BLANK_EN
            seen_q  <= seen_d;
`endif
        end
    end

    assign BCD_ERR = err_q;

endmodule
